// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions for the MIPS core: FSM states, opcode/funct
// constants used for next-PC selection, and fetch error codes.
package mips_pkg;

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_EXEC,
      S_HALT
   } fetch_state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] FUNCT_JR = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_TIMEOUT  = 2'b01,
      ERR_MISALIGN = 2'b10
   } fetch_err_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and a multi-cycle instruction memory (slave).
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: jr > j/jal > relative branch > sequential,
// plus a flag for a target that is not word aligned.
module next_pc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic        dobranch,
   input  logic        dojump,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] pc_plus4;
   logic [31:0] br_offset;
   logic        is_jr;

   assign pc_plus4  = pc + 32'd4;
   assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign is_jr     = (instr[31:26] == OP_RTYPE) && (instr[5:0] == FUNCT_JR);

   // NOTE: every combinational output gets a default before the branches so
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      next_pc = pc_plus4;
      if (dojump && is_jr) begin
         next_pc = jr_target;
      end else if (dojump) begin
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (dobranch) begin
         next_pc = pc_plus4 + br_offset;
      end
   end

   assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches from a multi-cycle imem, holds the word
// for decode/execute and advances the PC on retire.
module instr_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 32
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_unit_if.master imem,
   output logic [31:0]        instr,
   output logic               instr_valid,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   input  logic               retire,
   input  logic               dobranch,
   input  logic               dojump,
   input  logic [31:0]        jr_target,
   output logic               halted,
   output logic [1:0]         err_code,
   output logic [CNT_W-1:0]   retired_cnt
);

   localparam int WAIT_W = $clog2(TIMEOUT) + 1;

   fetch_state_e      state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   fetch_err_e        err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0] next_pc;
   logic        misaligned;

   next_pc_calc u_next_pc_calc (
      .pc         (pc_q),
      .instr      (instr_q),
      .dobranch   (dobranch),
      .dojump     (dojump),
      .jr_target  (jr_target),
      .next_pc    (next_pc),
      .misaligned (misaligned)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the same pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         wait_cnt_q <= '0;
         err_q      <= ERR_NONE;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         S_BOOT: state_d = S_REQ;
         S_REQ: begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (imem.imem_rvalid) begin
               instr_d = imem.imem_rdata;
               state_d = S_EXEC;
            end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
               err_d   = ERR_TIMEOUT;
               state_d = S_HALT;
            end
         end
         S_EXEC: begin
            if (retire) begin
               cnt_d = cnt_q + CNT_W'(1);
               // A misaligned target still counts as retired but freezes pc.
               if (misaligned) begin
                  err_d   = ERR_MISALIGN;
                  state_d = S_HALT;
               end else begin
                  pc_d    = next_pc;
                  state_d = S_REQ;
               end
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   assign imem.imem_req  = (state_q == S_REQ);
   assign imem.imem_addr = pc_q;
   assign instr          = instr_q;
   assign instr_valid    = (state_q == S_EXEC);
   assign pc             = pc_q;
   assign pc_plus4       = pc_q + 32'd4;
   assign halted         = (state_q == S_HALT);
   assign err_code       = err_q;
   assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized fetch/retire traffic against an address-level reference model.
module tb_instr_fetch_unit;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr, pc, pc_plus4, jr_target, retired_cnt;
   logic        instr_valid, retire, dobranch, dojump, halted;
   logic [1:0]  err_code;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .TIMEOUT  (TIMEOUT),
      .CNT_W    (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem        (bus.master),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .retire      (retire),
      .dobranch    (dobranch),
      .dojump      (dojump),
      .jr_target   (jr_target),
      .halted      (halted),
      .err_code    (err_code),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   bit          m_halt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Architectural next-PC rule from the ISA view of the instruction word.
   function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] iw,
                                               input logic br, input logic jp,
                                               input logic [31:0] rs);
      logic [31:0] seq;
      int          off;
      seq = cur + 32'd4;
      if (jp && iw[31:26] == 6'd0 && iw[5:0] == 6'd8) return rs;
      if (jp) return (seq & 32'hF000_0000) | ({6'd0, iw[25:0]} * 32'd4);
      if (br) begin
         off = int'($signed(iw[15:0]));
         return seq + 32'(off * 4);
      end
      return seq;
   endfunction

   task automatic do_reset();
      reset           = 1'b1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      retire          = 1'b0;
      dobranch        = 1'b0;
      dojump          = 1'b0;
      jr_target       = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_halt",  {31'd0, halted}, 32'd0);
      check("rst_err",   {30'd0, err_code}, 32'd0);
      check("rst_cnt",   retired_cnt, 32'd0);
      check("rst_pc",    pc, 32'd0);
      check("rst_instr", instr, 32'd0);
      reset  = 1'b0;
      m_pc   = 32'd0;
      m_cnt  = 32'd0;
      m_halt = 1'b0;
   endtask

   // Called at a negedge; waits for the request and answers after lat cycles.
   task automatic fetch(input int lat, input logic [31:0] word, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20 && !bus.imem_req; k++) @(negedge clk);
      if (!bus.imem_req) begin
         check("req_seen", 32'd0, 32'd1);
         m_halt = 1'b1;
         return;
      end
      check("imem_addr", bus.imem_addr, m_pc);
      @(negedge clk);
      check("req_one_cycle", {31'd0, bus.imem_req}, 32'd0);
      repeat (lat - 1) @(negedge clk);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = word;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      check("instr_valid", {31'd0, instr_valid}, 32'd1);
      check("instr", instr, word);
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      ok = 1'b1;
   endtask

   task automatic do_retire(input int dly, input logic [31:0] word, input logic br,
                            input logic jp, input logic [31:0] rs);
      logic [31:0] nxt;
      repeat (dly) @(negedge clk);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, word);
      retire    = 1'b1;
      dobranch  = br;
      dojump    = jp;
      jr_target = rs;
      @(negedge clk);
      retire    = 1'b0;
      dobranch  = 1'b0;
      dojump    = 1'b0;
      jr_target = $urandom;
      nxt   = ref_next_pc(m_pc, word, br, jp, rs);
      m_cnt = m_cnt + 32'd1;
      check("retired_cnt", retired_cnt, m_cnt);
      check("valid_drop", {31'd0, instr_valid}, 32'd0);
      if (nxt[1:0] != 2'b00) begin
         check("halt_misalign", {31'd0, halted}, 32'd1);
         check("err_misalign", {30'd0, err_code}, 32'd2);
         check("pc_kept", pc, m_pc);
         m_halt = 1'b1;
      end else begin
         m_pc = nxt;
         check("not_halted", {31'd0, halted}, 32'd0);
         check("pc_next", pc, m_pc);
      end
   endtask

   task automatic run_instr(input int lat, input logic [31:0] word, input int dly,
                            input logic br, input logic jp, input logic [31:0] rs);
      bit ok;
      fetch(lat, word, ok);
      if (ok) do_retire(dly, word, br, jp, rs);
   endtask

   task automatic wait_req();
      for (int k = 0; k < 20 && !bus.imem_req; k++) @(negedge clk);
      check("req_seen", {31'd0, bus.imem_req}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          reqs;
      logic [31:0] word, rs;
      logic        br, jp;

      // 1: sequential fetch, latency 2, retire one cycle after valid
      do_reset();
      for (int i = 0; i < 3; i++) run_instr(2, 32'h0000_0020, 1, 1'b0, 1'b0, 32'd0);
      check("t1_cnt", retired_cnt, 32'd3);
      check("t1_addr", bus.imem_addr, 32'h0000_000C);

      // 2: branches at 0x100
      run_instr(2, 32'h03E0_0008, 0, 1'b0, 1'b1, 32'h0000_0100);
      run_instr(3, 32'h1000_FFFF, 0, 1'b1, 1'b0, 32'd0);
      check("t2_back", bus.imem_addr, 32'h0000_0100);
      run_instr(1, 32'h1000_0003, 2, 1'b1, 1'b0, 32'd0);
      check("t2_fwd", bus.imem_addr, 32'h0000_0110);

      // 3: jal from 0x0040_0020
      run_instr(1, 32'h03E0_0008, 0, 1'b0, 1'b1, 32'h0040_0020);
      run_instr(2, 32'h0C00_0040, 1, 1'b1, 1'b1, 32'd0);
      check("t3_jal", bus.imem_addr, 32'h0000_0100);

      // 4: jr to a misaligned target
      run_instr(2, 32'h0120_0008, 0, 1'b0, 1'b1, 32'h0000_0206);
      check("t4_halt", {31'd0, halted}, 32'd1);
      check("t4_err", {30'd0, err_code}, 32'd2);
      check("t4_pc", pc, 32'h0000_0100);
      reqs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.imem_req) reqs++;
      end
      check("t4_no_req", 32'(reqs), 32'd0);

      // 5: memory never answers
      do_reset();
      wait_req();
      @(negedge clk);
      repeat (TIMEOUT - 1) @(negedge clk);
      check("t5_not_yet", {31'd0, halted}, 32'd0);
      @(negedge clk);
      check("t5_halt", {31'd0, halted}, 32'd1);
      check("t5_err", {30'd0, err_code}, 32'd1);
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      check("t5_instr", instr, 32'd0);
      check("t5_valid", {31'd0, instr_valid}, 32'd0);
      check("t5_err_hold", {30'd0, err_code}, 32'd1);

      // 6: reset during the wait, stale rvalid afterwards
      do_reset();
      run_instr(1, 32'h2108_0001, 0, 1'b0, 1'b0, 32'd0);
      run_instr(1, 32'h2108_0001, 0, 1'b0, 1'b0, 32'd0);
      wait_req();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t6_pc", pc, 32'd0);
      check("t6_cnt", retired_cnt, 32'd0);
      check("t6_req", {31'd0, bus.imem_req}, 32'd0);
      check("t6_instr", instr, 32'd0);
      @(negedge clk);
      reset           = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h1234_5678;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      check("t6_stale_instr", instr, 32'd0);
      check("t6_stale_valid", {31'd0, instr_valid}, 32'd0);
      m_pc   = 32'd0;
      m_cnt  = 32'd0;
      m_halt = 1'b0;
      run_instr(2, 32'h0000_0020, 0, 1'b0, 1'b0, 32'd0);

      // Random traffic
      for (int i = 0; i < 120; i++) begin
         if (m_halt) do_reset();
         if ($urandom_range(0, 3) == 0) word = {6'd0, 20'($urandom), 6'h08};
         else                           word = $urandom;
         jp = ($urandom_range(0, 2) == 0);
         br = ($urandom_range(0, 1) == 0);
         case ($urandom_range(0, 7))
            0:       rs = $urandom;
            1:       rs = 32'hFFFF_FFFC;
            default: rs = $urandom & 32'hFFFF_FFFC;
         endcase
         run_instr($urandom_range(1, 6), word, $urandom_range(0, 3), br, jp, rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
